exc_seq: RTL

Exception sequencer for the multicycle MIPS core. Sits between the datapath/control unit and CP0: it samples exception requests and a synchronized external interrupt at each instruction commit, prioritizes them, and issues a single-cycle exception strobe with cause code and EPC value to CP0. It also steers the PC to the handler vector on entry and back to CP0's EPC on `eret`, tracks the exception level, and traps nested exceptions as a sticky double fault.

---
 rtl/exc_seq.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/exc_seq.sv
// exc_seq: exception sequencer between the multicycle MIPS datapath and CP0.
// It samples exception requests and a synchronized interrupt at each commit,
// picks one by fixed priority, and then runs the entry, return and
// double-fault sequences. Every output is a flop that loads its next value
// together with the next state.
//
// Handshake: there is no valid/ready pair here. instr_done qualifies every
// request input for one cycle. ex is a one-cycle strobe and CP0 captures
// ca/epc_out while it is high. pc_redirect tells the PC to load pc_target
// at the next edge.
module exc_seq #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0180
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_done,
    input  logic [31:0] pc_cur,
    input  logic        ov,
    input  logic        dz,
    input  logic        sys,
    input  logic        brk,
    input  logic        eret,
    input  logic        irq,
    input  logic [31:0] epc_in,
    output logic        ex,
    output logic [31:0] ca,
    output logic [31:0] epc_out,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        stall,
    output logic        exl,
    output logic        double_fault,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_ENTER = 3'd1,
        ST_EXL   = 3'd2,
        ST_ERET  = 3'd3,
        ST_HALT  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        irq_meta_q, irq_s_q;
    logic        ex_q, ex_d;
    logic [31:0] ca_q, ca_d;
    logic [31:0] epc_out_q, epc_out_d;
    logic        pc_redirect_q, pc_redirect_d;
    logic [31:0] pc_target_q, pc_target_d;
    logic        stall_q, stall_d;
    logic        exl_q, exl_d;
    logic        double_fault_q, double_fault_d;

    logic        sync_exc;
    logic [4:0]  exc_code;
    logic [31:0] cause_word;
    logic [31:0] epc_value;

    // Two-flop synchronizer for the asynchronous interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_meta_q <= 1'b0;
            irq_s_q    <= 1'b0;
        end else begin
            irq_meta_q <= irq;
            irq_s_q    <= irq_meta_q;
        end
    end

    // Fixed-priority event encoding: dz > ov > sys > brk > irq.
    always_comb begin
        sync_exc   = dz | ov | sys | brk;
        exc_code   = 5'd0;
        if (dz)       exc_code = 5'd15;
        else if (ov)  exc_code = 5'd12;
        else if (sys) exc_code = 5'd8;
        else if (brk) exc_code = 5'd9;
        cause_word = {25'd0, exc_code, 2'b00};
        if (!sync_exc) cause_word[10] = 1'b1;
        // Interrupts resume after the completed instruction; faults re-execute it.
        epc_value  = sync_exc ? pc_cur : pc_cur + 32'd4;
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d        = state_q;
        ex_d           = 1'b0;
        ca_d           = 32'd0;
        epc_out_d      = 32'd0;
        pc_redirect_d  = 1'b0;
        pc_target_d    = 32'd0;
        stall_d        = 1'b0;
        exl_d          = 1'b0;
        double_fault_d = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (instr_done && (sync_exc || irq_s_q)) begin
                    state_d       = ST_ENTER;
                    ex_d          = 1'b1;
                    ca_d          = cause_word;
                    epc_out_d     = epc_value;
                    pc_redirect_d = 1'b1;
                    pc_target_d   = HANDLER_ADDR;
                    stall_d       = 1'b1;
                end
            end
            ST_ENTER: begin
                state_d = ST_EXL;
                exl_d   = 1'b1;
            end
            ST_EXL: begin
                exl_d = 1'b1;
                if (instr_done && sync_exc) begin
                    state_d        = ST_HALT;
                    stall_d        = 1'b1;
                    double_fault_d = 1'b1;
                end else if (instr_done && eret) begin
                    state_d       = ST_ERET;
                    pc_redirect_d = 1'b1;
                    pc_target_d   = epc_in;
                    stall_d       = 1'b1;
                end
            end
            ST_ERET: begin
                state_d = ST_RUN;
            end
            ST_HALT: begin
                stall_d        = 1'b1;
                exl_d          = 1'b1;
                double_fault_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_RUN;
            ex_q           <= 1'b0;
            ca_q           <= 32'd0;
            epc_out_q      <= 32'd0;
            pc_redirect_q  <= 1'b0;
            pc_target_q    <= 32'd0;
            stall_q        <= 1'b0;
            exl_q          <= 1'b0;
            double_fault_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ex_q           <= ex_d;
            ca_q           <= ca_d;
            epc_out_q      <= epc_out_d;
            pc_redirect_q  <= pc_redirect_d;
            pc_target_q    <= pc_target_d;
            stall_q        <= stall_d;
            exl_q          <= exl_d;
            double_fault_q <= double_fault_d;
        end
    end

    assign ex           = ex_q;
    assign ca           = ca_q;
    assign epc_out      = epc_out_q;
    assign pc_redirect  = pc_redirect_q;
    assign pc_target    = pc_target_q;
    assign stall        = stall_q;
    assign exl          = exl_q;
    assign double_fault = double_fault_q;
    assign dbg_state    = state_q;

endmodule
